// File: rtl/tlul_host_arb.sv
// TL-UL types shared by the host arbiter and its neighbours, followed by the
// round-robin arbiter that multiplexes NUM_HOSTS hosts onto one device port.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_host_arb #(
  parameter int unsigned NUM_HOSTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  tlul_pkg::tl_h2d_t [NUM_HOSTS-1:0]     tl_h2d_host_i,
  output tlul_pkg::tl_d2h_t [NUM_HOSTS-1:0]     tl_d2h_host_o,
  output tlul_pkg::tl_h2d_t                     tl_h2d_dev_o,
  input  tlul_pkg::tl_d2h_t                     tl_d2h_dev_i,
  output logic [$clog2(NUM_HOSTS)-1:0]          grant_o,
  output logic                                  busy_o,
  output logic                                  timeout_err_o
);

  localparam int unsigned GW = $clog2(NUM_HOSTS);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    ERR
  } state_e;

  state_e            state;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     winner;
  logic [GW-1:0]     next_ptr;
  logic              found;
  int unsigned       idx;
  logic [CNT_W-1:0]  count;
  logic [2:0]        lat_op;
  logic [7:0]        lat_src;
  logic [1:0]        lat_size;
  logic              a_fire;
  logic              d_fire;
  tlul_pkg::tl_h2d_t gnt_req;

  assign gnt_req = tl_h2d_host_i[grant_o];

  // Scan starts at rr_ptr and wraps, so the last-served host ranks lowest.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_HOSTS; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_HOSTS) idx = idx - NUM_HOSTS;
      if (!found && tl_h2d_host_i[idx].a_valid) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  assign next_ptr = (32'(grant_o) == NUM_HOSTS - 1) ? '0 : grant_o + 1'b1;

  assign a_fire = (state == ADDR) && gnt_req.a_valid && tl_d2h_dev_i.a_ready;
  assign d_fire = (state == RESP) && tl_d2h_dev_i.d_valid && gnt_req.d_ready;

  // A handshake on the limit cycle takes precedence over the timeout.
  assign timeout_err_o = (state == RESP) && !d_fire && (count == LIMIT);
  assign busy_o        = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_o  <= '0;
      count    <= '0;
      lat_op   <= '0;
      lat_src  <= '0;
      lat_size <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_o <= winner;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (a_fire) begin
            lat_op   <= gnt_req.a_opcode;
            lat_src  <= gnt_req.a_source;
            lat_size <= gnt_req.a_size;
            count    <= '0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (d_fire) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (count == LIMIT) begin
            state <= ERR;
          end else begin
            count <= count + 1'b1;
          end
        end
        ERR: begin
          if (gnt_req.d_ready) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Device d_ready stays high outside RESP so stray responses are sunk.
  always_comb begin
    tl_h2d_dev_o         = gnt_req;
    tl_h2d_dev_o.a_valid = (state == ADDR) && gnt_req.a_valid;
    tl_h2d_dev_o.d_ready = (state == RESP) ? gnt_req.d_ready : 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_HOSTS; i++) begin
      tl_d2h_host_o[i] = '0;
      if (GW'(i) == grant_o) begin
        case (state)
          ADDR: tl_d2h_host_o[i].a_ready = tl_d2h_dev_i.a_ready;
          RESP: begin
            tl_d2h_host_o[i]         = tl_d2h_dev_i;
            tl_d2h_host_o[i].a_ready = 1'b0;
          end
          ERR: begin
            tl_d2h_host_o[i].d_valid  = 1'b1;
            tl_d2h_host_o[i].d_error  = 1'b1;
            tl_d2h_host_o[i].d_data   = '1;
            tl_d2h_host_o[i].d_source = lat_src;
            tl_d2h_host_o[i].d_size   = lat_size;
            tl_d2h_host_o[i].d_opcode = (lat_op == tlul_pkg::Get) ?
                                        tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Scoreboard bench for tlul_host_arb: directed transactions push expected
// device-side A beats and host-side D beats; a negedge monitor pops and compares.
module tb_tlul_host_arb;
  import tlul_pkg::*;

  localparam int unsigned NH = 2;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  tl_h2d_t [NH-1:0] h2d;
  tl_d2h_t [NH-1:0] d2h;
  tl_h2d_t          dev_req;
  tl_d2h_t          dev_rsp;
  logic [0:0]       grant;
  logic             busy;
  logic             terr;

  int vectors     = 0;
  int miscompares = 0;
  int terr_seen   = 0;

  typedef struct {
    int          host;
    logic [31:0] data;
    logic [2:0]  op;
    logic        err;
    logic [7:0]  src;
  } exp_d_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
    logic [7:0]  src;
  } exp_a_t;

  exp_d_t exp_d[$];
  exp_a_t exp_a[$];

  always #5 clk = ~clk;

  tlul_host_arb #(
    .NUM_HOSTS     (NH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tl_h2d_host_i (h2d),
    .tl_d2h_host_o (d2h),
    .tl_h2d_dev_o  (dev_req),
    .tl_d2h_dev_i  (dev_rsp),
    .grant_o       (grant),
    .busy_o        (busy),
    .timeout_err_o (terr)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: host D handshakes, device A handshakes, timeout pulses.
  always @(negedge clk) begin
    exp_d_t e;
    exp_a_t a;
    if (!rst) begin
      for (int h = 0; h < NH; h++) begin
        if (d2h[h].d_valid && h2d[h].d_ready) begin
          if (exp_d.size() == 0) begin
            check($sformatf("stray_d_host%0d", h), 64'(d2h[h].d_valid), 64'd0);
          end else begin
            e = exp_d.pop_front();
            check("d_host", 64'(h), 64'(e.host));
            check("d_beat",
                  {18'd0, d2h[h].d_opcode, d2h[h].d_error, d2h[h].d_size, d2h[h].d_source, d2h[h].d_data},
                  {18'd0, e.op, e.err, 2'd2, e.src, e.data});
          end
        end
      end
      if (dev_req.a_valid && dev_rsp.a_ready) begin
        if (exp_a.size() == 0) begin
          check("stray_a", 64'(dev_req.a_valid), 64'd0);
        end else begin
          a = exp_a.pop_front();
          check("a_addr_data", {dev_req.a_address, dev_req.a_data}, {a.addr, a.data});
          check("a_op_src", {53'd0, dev_req.a_opcode, dev_req.a_source}, {53'd0, a.op, a.src});
        end
      end
      if (terr) terr_seen++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(int h, logic [2:0] op, logic [31:0] addr, logic [31:0] data, logic [7:0] src);
    h2d[h].a_valid   = 1'b1;
    h2d[h].a_opcode  = op;
    h2d[h].a_param   = 3'd0;
    h2d[h].a_size    = 2'd2;
    h2d[h].a_source  = src;
    h2d[h].a_address = addr;
    h2d[h].a_mask    = 4'hF;
    h2d[h].a_data    = data;
    exp_a.push_back('{addr, data, op, src});
  endtask

  task automatic wait_a(int h);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = d2h[h].a_ready;
    end
    check($sformatf("a_ready_host%0d", h), 64'(ok), 64'd1);
    check($sformatf("grant_host%0d", h), 64'(grant), 64'(h));
    @(posedge clk);
    #1;
    h2d[h].a_valid = 1'b0;
  endtask

  task automatic dev_resp(int h, int delay, logic [2:0] op, logic [31:0] data, logic [7:0] src);
    bit ok = 1'b0;
    repeat (delay) cyc();
    exp_d.push_back('{h, data, op, 1'b0, src});
    dev_rsp.d_valid  = 1'b1;
    dev_rsp.d_opcode = op;
    dev_rsp.d_data   = data;
    dev_rsp.d_source = src;
    dev_rsp.d_error  = 1'b0;
    dev_rsp.d_size   = 2'd2;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = dev_req.d_ready;
    end
    check("dev_d_ready", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    dev_rsp.d_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_busy_grant_terr"}, {61'd0, busy, grant, terr}, 64'd0);
    check({tag, "_host_hs"}, {60'd0, d2h[1].a_ready, d2h[1].d_valid, d2h[0].a_ready, d2h[0].d_valid}, 64'd0);
    check({tag, "_dev_valid_ready"}, {62'd0, dev_req.a_valid, dev_req.d_ready}, 64'd1);
  endtask

  initial begin
    int first;
    int t0;
    int bad;
    h2d = '0;
    h2d[0].d_ready = 1'b1;
    h2d[1].d_ready = 1'b1;
    dev_rsp = '0;
    dev_rsp.a_ready = 1'b1;

    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");

    // Single Put from host0, device answers three cycles after the A beat.
    cyc();
    set_req(0, PutFullData, 32'h4000_0000, 32'hDEAD_BEEF, 8'h05);
    wait_a(0);
    check("t1_busy_resp", 64'(busy), 64'd1);
    dev_resp(0, 3, AccessAck, 32'h0, 8'h05);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_grant", 64'(grant), 64'd0);

    // Simultaneous requests out of reset, then rr_ptr=1 favours host1.
    do_reset();
    set_req(0, Get, 32'h4000_0100, 32'h0, 8'h10);
    set_req(1, Get, 32'h4000_0200, 32'h0, 8'h11);
    wait_a(0);
    dev_resp(0, 1, AccessAckData, 32'h0000_1111, 8'h10);
    wait_a(1);
    dev_resp(1, 1, AccessAckData, 32'h0000_2222, 8'h11);
    set_req(0, Get, 32'h4000_0300, 32'h0, 8'h12);
    wait_a(0);
    dev_resp(0, 0, AccessAckData, 32'h0000_3333, 8'h12);
    set_req(1, Get, 32'h4000_0400, 32'h0, 8'h13);
    set_req(0, Get, 32'h4000_0500, 32'h0, 8'h14);
    wait_a(1);
    dev_resp(1, 2, AccessAckData, 32'h0000_4444, 8'h13);
    wait_a(0);
    dev_resp(0, 2, AccessAckData, 32'h0000_5555, 8'h14);

    // Timeout on host1 Get: pulse on the 16th RESP cycle, then error beat.
    set_req(1, Get, 32'h5000_0000, 32'h0, 8'h20);
    wait_a(1);
    exp_d.push_back('{1, 32'hFFFF_FFFF, AccessAckData, 1'b1, 8'h20});
    t0 = terr_seen;
    first = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (terr && first == 0) first = k;
    end
    check("t3_timeout_cycle", 64'(first), 64'd16);
    check("t3_timeout_pulses", 64'(terr_seen - t0), 64'd1);
    cyc();
    dev_rsp.d_valid  = 1'b1;
    dev_rsp.d_opcode = AccessAckData;
    dev_rsp.d_data   = 32'hCAFE_F00D;
    dev_rsp.d_source = 8'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_late_dropped", {61'd0, d2h[1].d_valid, d2h[0].d_valid, dev_req.d_ready}, 64'd1);
    end
    cyc();
    dev_rsp.d_valid = 1'b0;

    // Response lands exactly on the counter limit: handshake wins.
    set_req(1, Get, 32'h5000_0010, 32'h0, 8'h21);
    wait_a(1);
    t0 = terr_seen;
    dev_resp(1, TO - 1, AccessAckData, 32'h1234_5678, 8'h21);
    check("t4_no_timeout", 64'(terr_seen - t0), 64'd0);

    // Device stalls a_ready for 40 cycles; no timeout in ADDR, host1 blocked.
    dev_rsp.a_ready = 1'b0;
    set_req(0, PutFullData, 32'h4000_0600, 32'hA5A5_5A5A, 8'h30);
    cyc();
    cyc();
    set_req(1, Get, 32'h4000_0700, 32'h0, 8'h31);
    t0 = terr_seen;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d2h[0].a_ready || d2h[1].a_ready || !busy || grant != 1'b0 || !dev_req.a_valid) bad++;
    end
    check("t5_stall_cycles_bad", 64'(bad), 64'd0);
    check("t5_no_timeout", 64'(terr_seen - t0), 64'd0);
    cyc();
    dev_rsp.a_ready = 1'b1;
    wait_a(0);
    dev_resp(0, 2, AccessAck, 32'h0, 8'h30);
    wait_a(1);

    // Reset during RESP with a pending device response.
    h2d[1].d_ready   = 1'b0;
    dev_rsp.d_valid  = 1'b1;
    dev_rsp.d_opcode = AccessAckData;
    dev_rsp.d_data   = 32'h0BAD_0BAD;
    dev_rsp.d_source = 8'h31;
    cyc();
    do_reset();
    @(negedge clk);
    check_idle_outputs("t6_reset");
    cyc();
    h2d[1].d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_resp", {62'd0, d2h[1].d_valid, d2h[0].d_valid}, 64'd0);
    end
    cyc();
    dev_rsp.d_valid = 1'b0;
    cyc();

    check("exp_d_drained", 64'(exp_d.size()), 64'd0);
    check("exp_a_drained", 64'(exp_a.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
